// File: rtl/mxbus_pkg.sv
// Shared types for the MX Bus initiator and its watchdog.
package mxbus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    START,
    WAIT_CPL,
    RESP
  } mxbus_mst_state_t;

endpackage

// File: rtl/mxbus_mst_wdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags the limit cycle.
module mxbus_mst_wdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  // Saturates on the limit cycle; the master always leaves the counting states then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LAST)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = enable && (count_reg == LAST);

endmodule

// File: rtl/mxbus_master.sv
// MX Bus initiator: one outstanding single-beat transaction, fully registered outputs.
// Optional watchdog timeout enabled with the MXBUS_MST_TIMEOUT_EN macro.
module mxbus_master
  import mxbus_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  m0_wr_txn_start,
  output logic [ADDR_WIDTH-1:0] m0_wr_addr,
  output logic [DATA_WIDTH-1:0] m0_wr_data,
  input  logic                  m0_wr_ready,
  input  logic                  m0_wr_txn_ack,
  input  logic                  m0_wr_txn_cpl,
  output logic                  m0_rd_txn_start,
  output logic [ADDR_WIDTH-1:0] m0_rd_addr,
  input  logic [DATA_WIDTH-1:0] m0_rd_data,
  input  logic                  m0_rd_ready,
  input  logic                  m0_rd_txn_ack,
  input  logic                  m0_rd_txn_cpl
);
  mxbus_mst_state_t      state_reg, state_next;
  logic                  we_reg, we_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  wr_start_reg, wr_start_next;
  logic                  rd_start_reg, rd_start_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [DATA_WIDTH-1:0] rdata_reg, rdata_next;
  logic                  err_reg, err_next;
  logic                  req_ready_reg, req_ready_next;
  logic                  wdog_expired;

  logic sel_ready, sel_ack, sel_cpl, accept;

  assign sel_ready = we_reg ? m0_wr_ready   : m0_rd_ready;
  assign sel_ack   = we_reg ? m0_wr_txn_ack : m0_rd_txn_ack;
  assign sel_cpl   = we_reg ? m0_wr_txn_cpl : m0_rd_txn_cpl;
  assign accept    = (state_reg == IDLE) && req_valid;

`ifdef MXBUS_MST_TIMEOUT_EN
  mxbus_mst_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable ((state_reg == WAIT_RDY) || (state_reg == START) || (state_reg == WAIT_CPL)),
    .expired(wdog_expired)
  );
`else
  // No watchdog: the limit never applies, the legal range excludes 0.
  assign wdog_expired = (TIMEOUT_CYCLES == 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wr_start_reg  <= 1'b0;
      rd_start_reg  <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      req_ready_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      we_reg        <= we_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      wr_start_reg  <= wr_start_next;
      rd_start_reg  <= rd_start_next;
      rsp_valid_reg <= rsp_valid_next;
      rdata_reg     <= rdata_next;
      err_reg       <= err_next;
      req_ready_reg <= req_ready_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    we_next        = we_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wr_start_next  = wr_start_reg;
    rd_start_next  = rd_start_reg;
    rsp_valid_next = rsp_valid_reg;
    rdata_next     = rdata_reg;
    err_next       = err_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          we_next    = req_we;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          // Channel choice uses the incoming we since we_reg updates on this same edge.
          if (req_we ? m0_wr_ready : m0_rd_ready) begin
            wr_start_next = req_we;
            rd_start_next = !req_we;
            state_next    = START;
          end else begin
            state_next = WAIT_RDY;
          end
        end
      end
      WAIT_RDY: begin
        if (sel_ready) begin
          wr_start_next = we_reg;
          rd_start_next = !we_reg;
          state_next    = START;
        end else if (wdog_expired) begin
          err_next       = 1'b1;
          rdata_next     = '0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
      end
      START: begin
        if (sel_cpl) begin
          wr_start_next  = 1'b0;
          rd_start_next  = 1'b0;
          rdata_next     = we_reg ? '0 : m0_rd_data;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else if (sel_ack) begin
          wr_start_next = 1'b0;
          rd_start_next = 1'b0;
          state_next    = WAIT_CPL;
        end else if (wdog_expired) begin
          wr_start_next  = 1'b0;
          rd_start_next  = 1'b0;
          err_next       = 1'b1;
          rdata_next     = '0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
      end
      WAIT_CPL: begin
        if (sel_cpl) begin
          rdata_next     = we_reg ? '0 : m0_rd_data;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end else if (wdog_expired) begin
          err_next       = 1'b1;
          rdata_next     = '0;
          rsp_valid_next = 1'b1;
          state_next     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          err_next       = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    req_ready_next = (state_next == IDLE);
  end

  assign req_ready       = req_ready_reg;
  assign rsp_valid       = rsp_valid_reg;
  assign rsp_rdata       = rdata_reg;
  assign rsp_err         = err_reg;
  assign m0_wr_txn_start = wr_start_reg;
  assign m0_wr_addr      = addr_reg;
  assign m0_wr_data      = wdata_reg;
  assign m0_rd_txn_start = rd_start_reg;
  assign m0_rd_addr      = addr_reg;

endmodule

// File: tb/tb_mxbus_master.sv
// Directed self-checking bench for mxbus_master with a switchable comb/registered/manual slave.
module tb_mxbus_master;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [7:0] req_addr = '0, req_wdata = '0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [7:0] rsp_rdata;
  logic       wr_start, rd_start;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic       wr_ready, wr_ack, wr_cpl, rd_ready, rd_ack, rd_cpl;

  // Slave mode: 0 = same-cycle slave, 1 = registered slave, 2 = manually driven
  int         mode = 0;
  logic       man_ready = 1'b1, man_ack = 1'b0, man_cpl = 1'b0;
  logic [7:0] man_data = '0;
  logic       ack_r = 1'b0, drop_r = 1'b0;
  logic [7:0] data_r = '0;
  logic [7:0] mem [256];

  int tests_run = 0, tests_failed = 0, both_hi = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  mxbus_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m0_wr_txn_start(wr_start), .m0_wr_addr(wr_addr), .m0_wr_data(wr_data),
    .m0_wr_ready(wr_ready), .m0_wr_txn_ack(wr_ack), .m0_wr_txn_cpl(wr_cpl),
    .m0_rd_txn_start(rd_start), .m0_rd_addr(rd_addr), .m0_rd_data(rd_data),
    .m0_rd_ready(rd_ready), .m0_rd_txn_ack(rd_ack), .m0_rd_txn_cpl(rd_cpl)
  );

  always_comb begin
    wr_ready = man_ready; rd_ready = man_ready;
    wr_ack = man_ack; wr_cpl = man_cpl; rd_ack = man_ack; rd_cpl = man_cpl;
    rd_data = man_data;
    if (mode == 0) begin
      wr_ready = 1'b1; rd_ready = 1'b1;
      wr_ack = wr_start; wr_cpl = wr_start; rd_ack = rd_start; rd_cpl = rd_start;
      rd_data = rom(rd_addr);
    end else if (mode == 1) begin
      wr_ready = !drop_r; rd_ready = !drop_r;
      wr_ack = ack_r; wr_cpl = ack_r; rd_ack = ack_r; rd_cpl = ack_r;
      rd_data = data_r;
    end
  end

  always @(posedge clk) begin
    if (mode == 1) begin
      if (ack_r) begin
        ack_r <= 1'b0; drop_r <= 1'b1;
      end else begin
        drop_r <= 1'b0;
        if (wr_start || rd_start) begin
          ack_r  <= 1'b1;
          data_r <= rd_start ? rom(rd_addr) : 8'h00;
          if (wr_start) mem[wr_addr] <= wr_data;
        end
      end
    end else begin
      ack_r <= 1'b0; drop_r <= 1'b0;
      if (mode == 0 && wr_start) mem[wr_addr] <= wr_data;
    end
  end

  always @(negedge clk) if (wr_start && rd_start) both_hi++;

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    tests_run++; if ({rsp_valid, rsp_err, wr_start, rd_start} !== 4'b0) begin tests_failed++; $display("FAIL reset_ctrl: got %b expected 0000", {rsp_valid, rsp_err, wr_start, rd_start}); end
    tests_run++; if ({rsp_rdata, wr_addr, wr_data, rd_addr} !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", {rsp_rdata, wr_addr, wr_data, rd_addr}); end
    rst = 1'b1;
    @(negedge clk);
    $display("[TB] reset released");
  endtask

  task automatic test_comb_read();
    mode = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if ({rd_start, wr_start, rsp_valid, req_ready} !== 4'b1000) begin tests_failed++; $display("FAIL comb_rd_e0: got %b expected 1000", {rd_start, wr_start, rsp_valid, req_ready}); end
    tests_run++; if (rd_addr !== 8'h10) begin tests_failed++; $display("FAIL comb_rd_addr: got %h expected 10", rd_addr); end
    @(negedge clk);
    tests_run++; if ({rd_start, rsp_valid, rsp_err} !== 3'b010) begin tests_failed++; $display("FAIL comb_rd_e1: got %b expected 010", {rd_start, rsp_valid, rsp_err}); end
    tests_run++; if (rsp_rdata !== 8'hA5) begin tests_failed++; $display("FAIL comb_rd_data: got %h expected a5", rsp_rdata); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests_run++; if ({rsp_valid, req_ready} !== 2'b01) begin tests_failed++; $display("FAIL comb_rd_done: got %b expected 01", {rsp_valid, req_ready}); end
    $display("[TB] read  addr=10 rdata=%h err=%b", rsp_rdata, rsp_err);
  endtask

  task automatic test_reg_write();
    mode = 1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h3C; req_wdata = 8'h5A;
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if ({wr_start, rd_start, wr_addr, wr_data} !== {2'b10, 8'h3C, 8'h5A}) begin tests_failed++; $display("FAIL reg_wr_e0: got %b %h %h expected 10 3c 5a", {wr_start, rd_start}, wr_addr, wr_data); end
    @(negedge clk);
    tests_run++; if ({wr_start, rsp_valid} !== 2'b10) begin tests_failed++; $display("FAIL reg_wr_e1: got %b expected 10", {wr_start, rsp_valid}); end
    @(negedge clk);
    tests_run++; if ({wr_start, rsp_valid, rsp_rdata} !== {2'b01, 8'h00}) begin tests_failed++; $display("FAIL reg_wr_e2: got %b %h expected 01 00", {wr_start, rsp_valid}, rsp_rdata); end
    tests_run++; if (mem[8'h3C] !== 8'h5A) begin tests_failed++; $display("FAIL reg_wr_mem: got %h expected 5a", mem[8'h3C]); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);
    tests_run++; if ({rsp_valid, wr_start} !== 2'b00) begin tests_failed++; $display("FAIL reg_wr_once: got %b expected 00", {rsp_valid, wr_start}); end
    $display("[TB] write addr=3c wdata=5a mem=%h", mem[8'h3C]);
  endtask

  task automatic test_ready_wait();
    mode = 2; man_ready = 1'b0; man_ack = 1'b0; man_cpl = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h20;
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL rdy_busy: got %b expected 0", req_ready); end
    for (int i = 0; i < 5; i++) begin
      tests_run++; if ({rd_start, wr_start} !== 2'b00) begin tests_failed++; $display("FAIL rdy_wait%0d: got %b expected 00", i, {rd_start, wr_start}); end
      @(negedge clk);
    end
    man_ready = 1'b1;
    @(negedge clk);
    tests_run++; if ({rd_start, wr_start} !== 2'b10) begin tests_failed++; $display("FAIL rdy_start: got %b expected 10", {rd_start, wr_start}); end
    man_cpl = 1'b1; man_data = 8'h33;
    @(negedge clk);
    man_cpl = 1'b0;
    tests_run++; if ({rd_start, rsp_valid, rsp_rdata} !== {2'b01, 8'h33}) begin tests_failed++; $display("FAIL rdy_rsp: got %b %h expected 01 33", {rd_start, rsp_valid}, rsp_rdata); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests_run++; if (both_hi !== 0) begin tests_failed++; $display("FAIL both_start: got %0d expected 0", both_hi); end
    $display("[TB] read  addr=20 after ready wait rdata=%h", rsp_rdata);
  endtask

  task automatic test_split_ack();
    mode = 2; man_ready = 1'b1; man_ack = 1'b0; man_cpl = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h44;
    @(negedge clk);
    req_valid = 1'b0;
    tests_run++; if (rd_start !== 1'b1) begin tests_failed++; $display("FAIL split_start: got %b expected 1", rd_start); end
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    tests_run++; if ({rd_start, rsp_valid} !== 2'b00) begin tests_failed++; $display("FAIL split_ack: got %b expected 00", {rd_start, rsp_valid}); end
    repeat (2) @(negedge clk);
    tests_run++; if ({rd_start, rsp_valid} !== 2'b00) begin tests_failed++; $display("FAIL split_wait: got %b expected 00", {rd_start, rsp_valid}); end
    man_cpl = 1'b1; man_data = 8'h77;
    @(negedge clk);
    man_cpl = 1'b0; man_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tests_run++; if ({rsp_valid, rsp_rdata} !== {1'b1, 8'h77}) begin tests_failed++; $display("FAIL split_hold%0d: got %b %h expected 1 77", i, rsp_valid, rsp_rdata); end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests_run++; if ({rsp_valid, req_ready} !== 2'b01) begin tests_failed++; $display("FAIL split_done: got %b expected 01", {rsp_valid, req_ready}); end
    $display("[TB] read  addr=44 split ack/cpl rdata=77");
  endtask

`ifdef MXBUS_MST_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    mode = 2; man_ready = 1'b1; man_ack = 1'b0; man_cpl = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h99; req_wdata = 8'h11;
    cyc = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
    end while (!rsp_valid && cyc < 40);
    tests_run++; if (cyc !== 17) begin tests_failed++; $display("FAIL tmo_cycles: got %0d expected 17", cyc); end
    tests_run++; if ({rsp_err, rsp_rdata, wr_start} !== {1'b1, 8'h00, 1'b0}) begin tests_failed++; $display("FAIL tmo_rsp: got %b %h %b expected 1 00 0", rsp_err, rsp_rdata, wr_start); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests_run++; if ({rsp_err, rsp_valid} !== 2'b00) begin tests_failed++; $display("FAIL tmo_clear: got %b expected 00", {rsp_err, rsp_valid}); end
    mode = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    tests_run++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 8'hA5}) begin tests_failed++; $display("FAIL tmo_next: got %b %h expected 10 a5", {rsp_valid, rsp_err}, rsp_rdata); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    $display("[TB] write addr=99 timed out after %0d cycles, next read ok", cyc - 1);
  endtask
`endif

  task automatic test_reset_midflight();
    int cyc;
    mode = 2; man_ready = 1'b1; man_ack = 1'b0; man_cpl = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h55;
    @(negedge clk);
    req_valid = 1'b0;
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    tests_run++; if ({rd_start, rd_addr} !== {1'b0, 8'h55}) begin tests_failed++; $display("FAIL mid_wait_cpl: got %b %h expected 0 55", rd_start, rd_addr); end
    #2 rst = 1'b0;
    #1;
    tests_run++; if ({rsp_valid, req_ready, rd_start, rd_addr} !== {3'b010, 8'h00}) begin tests_failed++; $display("FAIL mid_async_clr: got %b %h expected 010 00", {rsp_valid, req_ready, rd_start}, rd_addr); end
    man_cpl = 1'b1;
    @(negedge clk);
    man_cpl = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_no_rsp: got %b expected 0", rsp_valid); end
    mode = 0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h62;
    cyc = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      cyc++;
    end while (!rsp_valid && cyc < 10);
    tests_run++; if ({rsp_valid, rsp_rdata} !== {1'b1, 8'hD7}) begin tests_failed++; $display("FAIL mid_fresh_rd: got %b %h expected 1 d7", rsp_valid, rsp_rdata); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    $display("[TB] reset in WAIT_CPL, fresh read addr=62 rdata=%h", rsp_rdata);
  endtask

  initial begin
    test_reset();
    test_comb_read();
    test_reg_write();
    test_ready_wait();
    test_split_ack();
`ifdef MXBUS_MST_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
